// File: rtl/psum_pingpong_buffer_pkg.sv
// psum_pingpong_buffer_pkg: layer-mode encodings, default widths and FSM states for the partial-sum buffer
package psum_pingpong_buffer_pkg;
  localparam int MODE_SCONV_1 = 0;
  localparam int MODE_SCONV_2 = 1;
  localparam int DEF_MAC_NUM = 112;
  localparam int DEF_ACC_W = 33;
  localparam int DEF_PSUM_W = 28;
  localparam int DEF_STORE_W = 17;
  localparam int DEF_FRAC_SHIFT = 11;
  localparam int DEF_N_MODE = 2;
  typedef enum logic [1:0] {IDLE, INIT0, INIT1, RUN} state_t;
endpackage

// File: rtl/psum_pingpong_buffer_sat_round_lane.sv
// sat_round_lane: one lane of optional round-half-up shift, optional ReLU, signed clamp IN_W->OUT_W (d in; relu in; q, sat out)
module sat_round_lane #(
  parameter int IN_W = 33,
  parameter int OUT_W = 28,
  parameter int SHIFT = 0,
  parameter int RND = 0
) (
  input  logic [IN_W-1:0]  d,
  input  logic             relu,
  output logic [OUT_W-1:0] q,
  output logic             sat
);
  localparam int RW = IN_W + 1;
  localparam logic [RW-1:0] RC = (RND != 0 && SHIFT > 0) ? RW'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
  logic signed [RW-1:0] s, r, c;
  logic [RW-OUT_W:0] hi;
  always_comb begin
    s = {d[IN_W-1], d} + RC;
    r = s >>> SHIFT;
    c = relu && r[RW-1] ? '0 : r;
    hi = c[RW-1:OUT_W-1];
    sat = !(&hi || !(|hi));
    q = sat ? {c[RW-1], {(OUT_W-1){!c[RW-1]}}} : c[OUT_W-1:0];
  end
endmodule

// File: rtl/psum_pingpong_buffer.sv
// psum_pingpong_buffer: two-bank saturating partial-sum buffer (bank write + ping-pong psum_out) with rounded/ReLU store path behind a valid/ready register and sticky sat/ovr flags
module psum_pingpong_buffer
  import psum_pingpong_buffer_pkg::*;
#(
  parameter int MAC_NUM = DEF_MAC_NUM,
  parameter int ACC_W = DEF_ACC_W,
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int STORE_W = DEF_STORE_W,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int N_MODE = DEF_N_MODE,
  localparam int MW = N_MODE > 1 ? $clog2(N_MODE) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MW-1:0]                mode,
  input  logic                         init,
  input  logic [PSUM_W-1:0]            bias_a,
  input  logic [PSUM_W-1:0]            bias_b,
  input  logic                         en,
  input  logic                         result_vld,
  input  logic [MAC_NUM*ACC_W-1:0]     result,
  input  logic                         relu_en,
  input  logic                         store_en,
  output logic [MAC_NUM*PSUM_W-1:0]    psum_out,
  output logic                         bank_sel,
  output logic                         ready,
  output logic                         store_vld,
  input  logic                         store_rdy,
  output logic [MAC_NUM*STORE_W-1:0]   store_data,
  output logic                         sat_flag,
  output logic                         ovr_flag
);
  state_t state_q, state_d;
  logic [MAC_NUM*PSUM_W-1:0] bank0, bank1, wr_psum;
  logic [MAC_NUM*STORE_W-1:0] st_val;
  logic [MAC_NUM-1:0] psat, ssat;
  logic [PSUM_W-1:0] pre_a, pre_b;
  logic run, wr, st, take, clr, pre_ok;
  for (genvar j = 0; j < MAC_NUM; j++) begin : g_lane
    sat_round_lane #(.IN_W(ACC_W), .OUT_W(PSUM_W), .SHIFT(0), .RND(0)) u_psum (
      .d(result[j*ACC_W +: ACC_W]), .relu(1'b0), .q(wr_psum[j*PSUM_W +: PSUM_W]), .sat(psat[j]));
    sat_round_lane #(.IN_W(ACC_W), .OUT_W(STORE_W), .SHIFT(FRAC_SHIFT), .RND(1)) u_store (
      .d(result[j*ACC_W +: ACC_W]), .relu(relu_en), .q(st_val[j*STORE_W +: STORE_W]), .sat(ssat[j]));
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = init ? INIT0 : IDLE;
      INIT0: state_d = INIT1;
      INIT1: state_d = RUN;
      RUN: state_d = init ? INIT0 : RUN;
      default: state_d = IDLE;
    endcase
  end
  assign run = state_q == RUN;
  assign wr = run && result_vld && en;
  assign st = run && result_vld && store_en;
  assign take = !store_vld || store_rdy;
  assign clr = init && (state_q == IDLE || run);
  // unknown modes leave the bank contents untouched during preload
  assign pre_ok = mode == MW'(MODE_SCONV_1) || mode == MW'(MODE_SCONV_2);
  assign pre_a = mode == MW'(MODE_SCONV_1) ? bias_a : '0;
  assign pre_b = mode == MW'(MODE_SCONV_1) ? bias_b : '0;
  assign ready = run;
  assign psum_out = bank_sel ? bank1 : bank0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bank0 <= '0;
      bank1 <= '0;
      bank_sel <= 1'b0;
      store_vld <= 1'b0;
      store_data <= '0;
      sat_flag <= 1'b0;
      ovr_flag <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT0 && pre_ok) bank0 <= {MAC_NUM{pre_a}};
      if (state_q == INIT1 && pre_ok) bank1 <= {MAC_NUM{pre_b}};
      if (wr && !bank_sel) bank1 <= wr_psum;
      if (wr && bank_sel) bank0 <= wr_psum;
      bank_sel <= !en || state_q == INIT1 ? 1'b0 : bank_sel ^ wr;
      if (st && take) store_data <= st_val;
      store_vld <= st ? 1'b1 : store_vld && !store_rdy;
      sat_flag <= !clr && (sat_flag || (wr && |psat) || (st && |ssat));
      ovr_flag <= !clr && (ovr_flag || (st && !take));
    end
  end
endmodule

// File: doc/psum_pingpong_buffer.md
Name: psum_pingpong_buffer

Overview:
Parametrised double-banked partial-sum buffer between the MAC array and the feature-map store path. Saturates each MAC_NUM-lane ACC_W accumulator result to PSUM_W and writes it into one of two banks. The other bank is fed back to the MACs as the running partial sum. Adds the following, none of which the first-generation buffer had:
- mode-selectable bias initialisation
- write-driven bank toggling
- round-and-saturate store quantisation with optional ReLU
- valid/ready store handshake
- sticky saturation and overrun flags

Parameters:
MAC_NUM, 112, number of parallel lanes
ACC_W, 33, signed accumulator width from MAC array
PSUM_W, 28, signed stored partial-sum width
STORE_W, 17, signed quantised output width
FRAC_SHIFT, 11, right shift applied on store path (must be < ACC_W)
N_MODE, 2, number of layer modes (mode input width = clog2(N_MODE), min 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mode  in  MW  layer mode; 0 = SCONV_1 (bias preload), 1 = SCONV_2 (zero preload)
init  in  1  one-cycle pulse; start bank preload
bias_a  in  PSUM_W  preload value for bank 0
bias_b  in  PSUM_W  preload value for bank 1
en  in  1  buffer enable; low freezes bank_sel at 0
result_vld  in  1  result lanes valid
result  in  MAC_NUM*ACC_W  signed MAC results, lane j at [j*ACC_W +: ACC_W]
relu_en  in  1  clamp negative store values to 0
store_en  in  1  qualify result_vld for store path
psum_out  out  MAC_NUM*PSUM_W  contents of bank[bank_sel]
bank_sel  out  1  read bank index
ready  out  1  high in RUN state
store_vld  out  1  store_data valid
store_rdy  in  1  downstream accepts store_data
store_data  out  MAC_NUM*STORE_W  quantised lanes
sat_flag  out  1  sticky: any lane saturated on either path
ovr_flag  out  1  sticky: store result dropped

Behaviour:
- Reset values:
  - FSM = IDLE
  - both banks, bank_sel, store_vld and store_data = 0
  - sat_flag and ovr_flag = 0
  - ready = 0
- Reset mid-preload or mid-handshake aborts immediately; no partial write survives the next cycle.
- FSM transitions:
  - IDLE --init--> INIT0 --(1 cycle)--> INIT1 --(1 cycle)--> RUN
  - RUN --init--> INIT0 (re-preload between output-channel groups)
  - init is ignored while in INIT0 or INIT1.
- INIT0 write, per mode:
  - mode 0: every lane of bank 0 = bias_a
  - mode 1: every lane of bank 0 = 0
  - other modes: bank 0 held unchanged
- INIT1 writes bank 1 by the same rule with bias_b. bank_sel is cleared to 0 in INIT1.
- RUN, bank write:
  - When result_vld & en, write sat_psum(result) into bank[~bank_sel] and toggle bank_sel on that same edge.
  - psum_out is combinational from bank[bank_sel], so the value written is visible on psum_out the cycle after the write.
  - en low: bank_sel forced to 0 and no bank writes.
- sat_psum, per lane: signed clamp of ACC_W to PSUM_W.
  - If the upper ACC_W-PSUM_W+1 bits are not all equal, output 0111..1 (positive) or 1000..0 (negative) according to the MSB.
  - Otherwise output the low PSUM_W bits.
- Store path (RUN only), when result_vld & store_en. Per lane:
  - r = (result + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, computed at ACC_W+1 width (round half up).
  - If relu_en and r < 0, r = 0.
  - Signed clamp r to STORE_W.
- Store output register:
  - Loads when (!store_vld | store_rdy); store_vld = 1 on the next edge.
  - store_vld & store_rdy with no new load: store_vld = 0 next cycle.
  - If store_vld & !store_rdy when a new store arrives: the register holds its old data, the new data is dropped, and ovr_flag is set.
- Flags: sat_flag is set when any lane clamps in either path. Both flags clear only on rst or on the init pulse.
- Latency:
  - result -> bank write: 1 cycle
  - result -> store_data: 1 cycle
  - no combinational path from result to any output.

Decomposition:
- Shared package (def_header): mode encodings MODE_SCONV_1 = 0, MODE_SCONV_2 = 1; default widths MAC_NUM, ACC_W, PSUM_W, STORE_W, FRAC_SHIFT.
- One sub-module: sat_round_lane, the per-lane combinational function, generated MAC_NUM times.
  - Parameters: IN_W, OUT_W, SHIFT, RND.
  - Outputs: the clamped value and a sat bit.
  - Used with SHIFT = 0, RND = 0 for the psum path and SHIFT = FRAC_SHIFT, RND = 1 for the store path.

Test Plan:
- Preload: mode 0, bias_a = 0x0000123, bias_b = 0x7FFFFFF, pulse init. After 2 cycles: lane 111 of bank 0 = 0x0000123, bank 1 = 0x7FFFFFF, ready = 1, bank_sel = 0, psum_out = bank 0.
- Ping-pong: three consecutive result_vld with lane 0 = 5, 6, 7 → bank_sel sequence 1, 0, 1; psum_out lane 0 shows 5, 6, 7 on the cycles after each write.
- PSUM saturation: lane 0 = +2^31, lane 1 = -2^32 → written 0x7FFFFFF and 0x8000000; sat_flag = 1 and stays set until the next init.
- Store rounding and ReLU:
  - relu_en = 0: 3072 → 2, 1023 → 0, 2^31 → 65535, -2^32 → -65536.
  - relu_en = 1: -4096 → 0.
- Handshake/overrun: hold store_rdy = 0 with store_vld = 1, issue a second store → store_data is unchanged and ovr_flag = 1. Raise store_rdy with no new store → store_vld = 0 the next cycle.
- Reset in INIT0 → FSM = IDLE, both banks = 0, ready = 0; a later init completes normally.
